ltssm_ts_decoder: RTL
=====================

# ltssm_ts_decoder

Per-lane receive-side ordered-set decoder that feeds the LTSSM Configuration stage. It scans the descrambled 8b/10b-decoded symbol stream of each lane and recognises complete TS1 and TS2 ordered sets and logical-idle runs. It presents per-lane valid pulses plus the decoded link number, lane number, rate ID and training-control fields in the flattened packed format the Configuration stage consumes.

## Interface
- `MAX_NUM_LANES`, default 4: number of lanes decoded in parallel.
- `IDLE_RUN`, default 8: consecutive idle symbols required per `idle_valid_o` pulse, range 1..255.
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: reset. Reset is synchronous and active-high; one clock.
- `lane_en_i`, input, MAX_NUM_LANES: per-lane decode enable.
- `rx_valid_i`, input, MAX_NUM_LANES: the lane's symbol is present this cycle.
- `rx_data_i`, input, MAX_NUM_LANES*8: per-lane symbol; lane n occupies bits [8n+7:8n].
- `rx_datak_i`, input, MAX_NUM_LANES: per-lane K-character flag.
- `ts1_valid_o`, output, MAX_NUM_LANES: one-cycle pulse when a complete TS1 is received.
- `ts2_valid_o`, output, MAX_NUM_LANES: one-cycle pulse when a complete TS2 is received.
- `idle_valid_o`, output, MAX_NUM_LANES: one-cycle pulse per IDLE_RUN consecutive idle symbols.
- `link_num_o`, output, MAX_NUM_LANES*8: symbol 1 of the last good TS.
- `lane_num_o`, output, MAX_NUM_LANES*8: symbol 2 of the last good TS.
- `rate_id_o`, output, MAX_NUM_LANES*8: symbol 4 of the last good TS.
- `training_ctrl_o`, output, MAX_NUM_LANES*8: symbol 5 of the last good TS.
- `link_pad_o`, output, MAX_NUM_LANES: symbol 1 of the last good TS was PAD (K23.7).
- `lane_pad_o`, output, MAX_NUM_LANES: symbol 2 of the last good TS was PAD (K23.7).

## Operation
- Symbol codes:
  - COM = 0xBC, K.
  - PAD = 0xF7, K.
  - TS1 identifier = 0x4A, D.
  - TS2 identifier = 0x45, D.
  - Idle = 0x00, D.
- Lanes are fully independent. Each lane runs its own FSM with states ST_HUNT, ST_FIELDS and ST_IDENT, plus a 4-bit symbol index.
- Stall rule: a cycle with `rx_valid_i` low is ignored. State, index and shadow fields hold.
- ST_HUNT:
  - On COM: go to ST_FIELDS with index 1.
  - On idle: increment the idle counter.
  - On any other symbol: clear the idle counter.
- ST_FIELDS (index 1..5):
  - Capture each symbol into a shadow register.
  - Index 1 and index 2 accept a D symbol or PAD; any other K symbol aborts.
  - Index 3 (N_FTS), index 4 and index 5 must be D; a K symbol aborts.
  - After index 5, go to ST_IDENT.
- ST_IDENT (index 6..15):
  - Index 6 must be 0x4A D or 0x45 D, which latches the set type; anything else aborts.
  - Index 7..15 must equal the latched identifier; a mismatch aborts.
  - At index 15 with a match: commit the shadow registers to the outputs, pulse `ts1_valid_o` or `ts2_valid_o`, and return to ST_HUNT.
- Abort rules:
  - Abort returns the lane to ST_HUNT and leaves the outputs unchanged.
  - COM received in any state restarts at index 1 (no abort pulse) and clears the idle counter.
- Idle counting:
  - The idle counter is 8-bit and counts only in ST_HUNT.
  - When it reaches IDLE_RUN, pulse `idle_valid_o` and reload the counter to 0.
- `lane_en_i` low: the lane is forced to ST_HUNT, its idle counter is cleared and its valid outputs are held 0. Field outputs hold.
- Reset: every output is 0, every FSM is in ST_HUNT, and every counter and shadow register is 0.

## Timing
- Latency: a valid pulse appears exactly one cycle after the clock edge that accepts symbol 15 (outputs are registered).
- Field outputs change in the same cycle as the valid pulse and are stable otherwise. Consumers may sample fields on any cycle.
- Back-to-back sets (COM immediately after symbol 15) produce pulses 16 valid cycles apart with no dead cycle.
- `rst_i` mid-set: the partially received set is discarded, with no pulse, on the next edge.
- Index 15 accepted in the same cycle that `lane_en_i` falls: no pulse, no commit (enable wins).

## Structure
- COM/PAD/identifier/idle codes and the FSM enum belong in `pcie_phy_pkg`; add them only if absent.
- One sub-module, `ts_lane_decoder`, handles a single lane. The top level is a generate loop that packs the per-lane outputs.
- Target size: ~200 lines of RTL total.

## Test plan
- Lane 0 receives COM, 0x01, 0x02, 0x1F, 0x02, 0x40, then 10×0x4A → `ts1_valid_o[0]` pulses once, with link=0x01, lane=0x02, rate=0x02, training_ctrl=0x40; no other lane pulses.
- Lane 1 receives a TS2 with PAD in symbols 1 and 2 → `ts2_valid_o[1]` pulses with `link_pad_o[1]`=1, `lane_pad_o[1]`=1 and link/lane=0xF7.
- TS1 in which symbol 10 is 0x45 → no pulse and fields unchanged. The next clean TS1 pulses normally.
- A TS1 stream with `rx_valid_i` low for 3 random cycles mid-set → exactly one pulse, delayed by 3 cycles.
- 16 consecutive idle symbols with IDLE_RUN=8 → two `idle_valid_o` pulses, 8 cycles apart. Inserting a non-idle symbol after 5 idles restarts the count.
- Assert `rst_i` at symbol 9 of a TS2, then release → no pulse, all outputs 0. The following TS2 decodes correctly.

Source files
------------

// File: rtl/pcie_phy_pkg.sv
// Shared PHY symbol codes and the per-lane ordered-set decoder state encoding.
// Pure declarations: no logic, no latency, no flow control.
package pcie_phy_pkg;

    localparam logic [7:0] SYM_COM    = 8'hBC;
    localparam logic [7:0] SYM_PAD    = 8'hF7;
    localparam logic [7:0] SYM_TS1_ID = 8'h4A;
    localparam logic [7:0] SYM_TS2_ID = 8'h45;
    localparam logic [7:0] SYM_IDLE   = 8'h00;

    localparam logic [3:0] TS_LAST_IDX = 4'd15;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_FIELDS,
        ST_IDENT
    } ts_state_e;

endpackage

// File: rtl/ts_lane_decoder.sv
// Single-lane TS1/TS2/idle-run recogniser; pulses and fields registered one cycle after the last symbol.
// No backpressure: rx_valid_i low simply freezes the lane, lane_en_i low parks it in hunt.
module ts_lane_decoder
    import pcie_phy_pkg::*;
#(
    parameter int IDLE_RUN = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       lane_en_i,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_datak_i,
    output logic       ts1_valid_o,
    output logic       ts2_valid_o,
    output logic       idle_valid_o,
    output logic [7:0] link_num_o,
    output logic [7:0] lane_num_o,
    output logic [7:0] rate_id_o,
    output logic [7:0] training_ctrl_o,
    output logic       link_pad_o,
    output logic       lane_pad_o
);

    localparam logic [7:0] IDLE_RUN_C = 8'(IDLE_RUN);

    ts_state_e   state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  idle_cnt_q, idle_cnt_d;
    logic        is_ts2_q, is_ts2_d;
    logic [7:0]  sh_link_q, sh_link_d, sh_lane_q, sh_lane_d;
    logic [7:0]  sh_rate_q, sh_rate_d, sh_tctrl_q, sh_tctrl_d;
    logic        sh_link_pad_q, sh_link_pad_d, sh_lane_pad_q, sh_lane_pad_d;
    logic        ts1_q, ts1_d, ts2_q, ts2_d, idle_q, idle_d;
    logic [7:0]  link_q, link_d, lane_q, lane_d, rate_q, rate_d, tctrl_q, tctrl_d;
    logic        link_pad_q, link_pad_d, lane_pad_q, lane_pad_d;

    logic        is_com, is_pad, is_idle, fields_ok;
    logic [7:0]  ident;

    assign is_com  = rx_datak_i && (rx_data_i == SYM_COM);
    assign is_pad  = rx_datak_i && (rx_data_i == SYM_PAD);
    assign is_idle = !rx_datak_i && (rx_data_i == SYM_IDLE);
    assign ident   = is_ts2_q ? SYM_TS2_ID : SYM_TS1_ID;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        idle_cnt_d    = idle_cnt_q;
        is_ts2_d      = is_ts2_q;
        sh_link_d     = sh_link_q;
        sh_lane_d     = sh_lane_q;
        sh_rate_d     = sh_rate_q;
        sh_tctrl_d    = sh_tctrl_q;
        sh_link_pad_d = sh_link_pad_q;
        sh_lane_pad_d = sh_lane_pad_q;
        ts1_d         = 1'b0;
        ts2_d         = 1'b0;
        idle_d        = 1'b0;
        link_d        = link_q;
        lane_d        = lane_q;
        rate_d        = rate_q;
        tctrl_d       = tctrl_q;
        link_pad_d    = link_pad_q;
        lane_pad_d    = lane_pad_q;
        fields_ok     = 1'b0;

        if (!lane_en_i) begin
            state_d    = ST_HUNT;
            idx_d      = 4'd0;
            idle_cnt_d = 8'd0;
        end else if (rx_valid_i) begin
            if (is_com) begin
                // COM always restarts a set, whatever was in flight.
                state_d    = ST_FIELDS;
                idx_d      = 4'd1;
                idle_cnt_d = 8'd0;
            end else begin
                unique case (state_q)
                    ST_HUNT: begin
                        if (is_idle) begin
                            if (idle_cnt_q + 8'd1 == IDLE_RUN_C) begin
                                idle_d     = 1'b1;
                                idle_cnt_d = 8'd0;
                            end else begin
                                idle_cnt_d = idle_cnt_q + 8'd1;
                            end
                        end else begin
                            idle_cnt_d = 8'd0;
                        end
                    end
                    ST_FIELDS: begin
                        case (idx_q)
                            4'd1: begin
                                fields_ok     = !rx_datak_i || is_pad;
                                sh_link_d     = rx_data_i;
                                sh_link_pad_d = rx_datak_i;
                            end
                            4'd2: begin
                                fields_ok     = !rx_datak_i || is_pad;
                                sh_lane_d     = rx_data_i;
                                sh_lane_pad_d = rx_datak_i;
                            end
                            4'd3: fields_ok = !rx_datak_i;
                            4'd4: begin
                                fields_ok = !rx_datak_i;
                                sh_rate_d = rx_data_i;
                            end
                            4'd5: begin
                                fields_ok  = !rx_datak_i;
                                sh_tctrl_d = rx_data_i;
                            end
                            default: fields_ok = 1'b0;
                        endcase
                        if (!fields_ok) begin
                            state_d = ST_HUNT;
                            idx_d   = 4'd0;
                        end else begin
                            idx_d = idx_q + 4'd1;
                            if (idx_q == 4'd5) begin
                                state_d = ST_IDENT;
                            end
                        end
                    end
                    ST_IDENT: begin
                        if (idx_q == 4'd6) begin
                            if (!rx_datak_i && (rx_data_i == SYM_TS1_ID || rx_data_i == SYM_TS2_ID)) begin
                                is_ts2_d = (rx_data_i == SYM_TS2_ID);
                                idx_d    = 4'd7;
                            end else begin
                                state_d = ST_HUNT;
                                idx_d   = 4'd0;
                            end
                        end else if (!rx_datak_i && rx_data_i == ident) begin
                            if (idx_q == TS_LAST_IDX) begin
                                ts1_d      = !is_ts2_q;
                                ts2_d      = is_ts2_q;
                                link_d     = sh_link_q;
                                lane_d     = sh_lane_q;
                                rate_d     = sh_rate_q;
                                tctrl_d    = sh_tctrl_q;
                                link_pad_d = sh_link_pad_q;
                                lane_pad_d = sh_lane_pad_q;
                                state_d    = ST_HUNT;
                                idx_d      = 4'd0;
                            end else begin
                                idx_d = idx_q + 4'd1;
                            end
                        end else begin
                            state_d = ST_HUNT;
                            idx_d   = 4'd0;
                        end
                    end
                    default: begin
                        state_d = ST_HUNT;
                        idx_d   = 4'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_HUNT;
            idx_q         <= 4'd0;
            idle_cnt_q    <= 8'd0;
            is_ts2_q      <= 1'b0;
            sh_link_q     <= 8'd0;
            sh_lane_q     <= 8'd0;
            sh_rate_q     <= 8'd0;
            sh_tctrl_q    <= 8'd0;
            sh_link_pad_q <= 1'b0;
            sh_lane_pad_q <= 1'b0;
            ts1_q         <= 1'b0;
            ts2_q         <= 1'b0;
            idle_q        <= 1'b0;
            link_q        <= 8'd0;
            lane_q        <= 8'd0;
            rate_q        <= 8'd0;
            tctrl_q       <= 8'd0;
            link_pad_q    <= 1'b0;
            lane_pad_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            idle_cnt_q    <= idle_cnt_d;
            is_ts2_q      <= is_ts2_d;
            sh_link_q     <= sh_link_d;
            sh_lane_q     <= sh_lane_d;
            sh_rate_q     <= sh_rate_d;
            sh_tctrl_q    <= sh_tctrl_d;
            sh_link_pad_q <= sh_link_pad_d;
            sh_lane_pad_q <= sh_lane_pad_d;
            ts1_q         <= ts1_d;
            ts2_q         <= ts2_d;
            idle_q        <= idle_d;
            link_q        <= link_d;
            lane_q        <= lane_d;
            rate_q        <= rate_d;
            tctrl_q       <= tctrl_d;
            link_pad_q    <= link_pad_d;
            lane_pad_q    <= lane_pad_d;
        end
    end

    assign ts1_valid_o     = ts1_q;
    assign ts2_valid_o     = ts2_q;
    assign idle_valid_o    = idle_q;
    assign link_num_o      = link_q;
    assign lane_num_o      = lane_q;
    assign rate_id_o       = rate_q;
    assign training_ctrl_o = tctrl_q;
    assign link_pad_o      = link_pad_q;
    assign lane_pad_o      = lane_pad_q;

endmodule

// File: rtl/ltssm_ts_decoder.sv
// Multi-lane TS1/TS2/idle decoder; one registered cycle of latency, lanes fully independent.
// No backpressure: stalled lanes (rx_valid_i low) hold their decode state.
module ltssm_ts_decoder
    import pcie_phy_pkg::*;
#(
    parameter int MAX_NUM_LANES = 4,
    parameter int IDLE_RUN      = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [MAX_NUM_LANES-1:0]   lane_en_i,
    input  logic [MAX_NUM_LANES-1:0]   rx_valid_i,
    input  logic [MAX_NUM_LANES*8-1:0] rx_data_i,
    input  logic [MAX_NUM_LANES-1:0]   rx_datak_i,
    output logic [MAX_NUM_LANES-1:0]   ts1_valid_o,
    output logic [MAX_NUM_LANES-1:0]   ts2_valid_o,
    output logic [MAX_NUM_LANES-1:0]   idle_valid_o,
    output logic [MAX_NUM_LANES*8-1:0] link_num_o,
    output logic [MAX_NUM_LANES*8-1:0] lane_num_o,
    output logic [MAX_NUM_LANES*8-1:0] rate_id_o,
    output logic [MAX_NUM_LANES*8-1:0] training_ctrl_o,
    output logic [MAX_NUM_LANES-1:0]   link_pad_o,
    output logic [MAX_NUM_LANES-1:0]   lane_pad_o
);

    for (genvar g = 0; g < MAX_NUM_LANES; g++) begin : g_lane
        ts_lane_decoder #(
            .IDLE_RUN (IDLE_RUN)
        ) u_lane (
            .clk_i           (clk_i),
            .rst_i           (rst_i),
            .lane_en_i       (lane_en_i[g]),
            .rx_valid_i      (rx_valid_i[g]),
            .rx_data_i       (rx_data_i[g*8 +: 8]),
            .rx_datak_i      (rx_datak_i[g]),
            .ts1_valid_o     (ts1_valid_o[g]),
            .ts2_valid_o     (ts2_valid_o[g]),
            .idle_valid_o    (idle_valid_o[g]),
            .link_num_o      (link_num_o[g*8 +: 8]),
            .lane_num_o      (lane_num_o[g*8 +: 8]),
            .rate_id_o       (rate_id_o[g*8 +: 8]),
            .training_ctrl_o (training_ctrl_o[g*8 +: 8]),
            .link_pad_o      (link_pad_o[g]),
            .lane_pad_o      (lane_pad_o[g])
        );
    end

endmodule
